// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   mdu_op_e : operation encodings (MULT, MULTU, DIV, DIVU)
//   state_e  : control FSM states
//   DATA_W   : operand width
//   ITER     : radix-2 iterations per operation
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    CALC = 2'b10,
    FIX  = 2'b11
  } state_e;

  // True for the two signed operations (MULT, DIV).
  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the EX stage and mdu_iter.
//   start, op, data1, data2, flush : requester -> unit
//   busy, done, hi, lo             : unit -> requester
// modport master is the pipeline side, modport slave is the unit.
interface mdu_iter_if;
  import mdu_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, data1, data2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, data1, data2, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mdu_iter_if.slave (start/op/data1/data2/flush in, busy/done/hi/lo out)
// Sequence: IDLE -> PREP (magnitudes and signs) -> CALC (32 radix-2 steps)
// -> FIX (sign correction, result write). One 64-bit working register holds
// {partial product, multiplier} for multiply and {remainder, quotient} for divide.
module mdu_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mdu_iter_if.slave   bus
);

  state_e              state_q, state_d;
  mdu_op_e             op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;        // raw dividend / multiplicand as latched
  logic [DATA_W-1:0]   b_q, b_d;        // raw, then magnitude after PREP
  logic [2*DATA_W-1:0] work_q, work_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                neg_res_q, neg_res_d;  // product / quotient sign
  logic                neg_rem_q, neg_rem_d;  // remainder sign (follows dividend)
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   abs_a_s, abs_b_s;
  logic [2*DATA_W-1:0] mul_next_s, div_next_s, prod_fix_s;
  logic [DATA_W:0]     mul_sum_s, rem_sh_s, div_diff_s;
  logic [DATA_W-1:0]   fix_hi_s, fix_lo_s;

  // Datapath: operand magnitudes, one shift-add / restoring step, sign fix-up.
  always_comb begin
    abs_a_s    = (is_signed_op(op_q) && a_q[DATA_W-1]) ? (32'd0 - a_q) : a_q;
    abs_b_s    = (is_signed_op(op_q) && b_q[DATA_W-1]) ? (32'd0 - b_q) : b_q;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole 64-bit register right by one.
    mul_sum_s  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next_s = {mul_sum_s, work_q[31:1]};

    // Divide: shift the next dividend bit into the remainder; the remainder is
    // always below 2*divisor, so bit 32 of the difference is a clean borrow flag.
    rem_sh_s   = work_q[63:31];
    div_diff_s = rem_sh_s - {1'b0, b_q};
    if (!div_diff_s[DATA_W]) begin
      div_next_s = {div_diff_s[31:0], work_q[30:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[31:0], work_q[30:0], 1'b0};
    end

    prod_fix_s = neg_res_q ? (64'd0 - work_q) : work_q;
    if (op_q[1]) begin
      // b_q holds the divisor magnitude here; zero means divide by zero.
      if (b_q == 32'd0) begin
        fix_hi_s = a_q;
        fix_lo_s = 32'hFFFF_FFFF;
      end else begin
        fix_hi_s = neg_rem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
        fix_lo_s = neg_res_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
      end
    end else begin
      fix_hi_s = prod_fix_s[63:32];
      fix_lo_s = prod_fix_s[31:0];
    end
  end

  // Control FSM next-state and register next values.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d = PREP;
          op_d    = mdu_op_e'(bus.op);
          a_d     = bus.data1;
          b_d     = bus.data2;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          state_d   = CALC;
          neg_res_d = is_signed_op(op_q) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
          neg_rem_d = is_signed_op(op_q) && a_q[DATA_W-1];
          b_d       = abs_b_s;
          work_d    = {32'd0, abs_a_s};
          cnt_d     = 5'd0;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          work_d = op_q[1] ? div_next_s : mul_next_s;
          cnt_d  = cnt_q + 5'd1;   // wraps 31 -> 0 on the last step
          if (cnt_q == 5'(ITER - 1)) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (bus.flush) begin
          done_d = 1'b0;
        end else begin
          hi_d   = fix_hi_s;
          lo_d   = fix_lo_s;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= MDU_MULT;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      work_q    <= 64'd0;
      cnt_q     <= 5'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter. Randomized and directed
// operations are compared against an arithmetic reference model; latency,
// flush, start rejection and reset behaviour are checked cycle by cycle.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_iter_if bus();

  mdu_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {hi, lo} from plain arithmetic on the operands.
  function automatic logic [63:0] ref_mdu(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sp;
    logic [63:0] ua;
    int          sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      2'b01: begin
        ua = {32'd0, a};
        return ua * {32'd0, b};
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation from a falling edge. Checks busy/done on every cycle,
  // then the result after edge k+34. Returns at the falling edge after k+34
  // with done high and start low. noise = 1 toggles start and scrambles the
  // operand inputs while busy; none of it may take effect.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic noise);
    logic [63:0] r;
    r = ref_mdu(op, a, b);
    bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b; bus.flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 34; n++) begin
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_window: cycle %0d busy=%b done=%b, required busy=1 done=0", n, bus.busy, bus.done);
      end
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.op    = 2'($urandom);
      bus.data1 = $urandom;
      bus.data2 = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_edge: done=%b busy=%b, required done=1 busy=0", bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.hi !== r[63:32] || bus.lo !== r[31:0]) begin
      n_bad++;
      $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
               op, a, b, bus.hi, bus.lo, r[63:32], r[31:0]);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  // Idle for n cycles: no done, not busy, hi/lo hold the expected values.
  task automatic idle(input int n);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
        n_bad++;
        $display("FAIL idle: done=%b busy=%b hi=%h lo=%h, required done=0 busy=0 hi=%h lo=%h",
                 bus.done, bus.busy, bus.hi, bus.lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.data1 = 32'd0; bus.data2 = 32'd0; bus.flush = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all zero", bus.busy, bus.done, bus.hi, bus.lo);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_vectors();
    logic [1:0]  v_op [5];
    logic [31:0] v_a  [5];
    logic [31:0] v_b  [5];
    logic [31:0] v_hi [5];
    logic [31:0] v_lo [5];
    v_op[0] = 2'b00; v_a[0] = 32'hFFFF_FFFE; v_b[0] = 32'd3;          v_hi[0] = 32'hFFFF_FFFF; v_lo[0] = 32'hFFFF_FFFA;
    v_op[1] = 2'b01; v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'hFFFF_FFFF;  v_hi[1] = 32'hFFFF_FFFE; v_lo[1] = 32'h0000_0001;
    v_op[2] = 2'b10; v_a[2] = 32'hFFFF_FFF9; v_b[2] = 32'd2;          v_hi[2] = 32'hFFFF_FFFF; v_lo[2] = 32'hFFFF_FFFD;
    v_op[3] = 2'b10; v_a[3] = 32'h8000_0000; v_b[3] = 32'hFFFF_FFFF;  v_hi[3] = 32'h0000_0000; v_lo[3] = 32'h8000_0000;
    v_op[4] = 2'b11; v_a[4] = 32'h0000_0064; v_b[4] = 32'd0;          v_hi[4] = 32'h0000_0064; v_lo[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], 1'b0);
      n_cmp++;
      if (bus.hi !== v_hi[i] || bus.lo !== v_lo[i]) begin
        n_bad++;
        $display("FAIL vector%0d: hi=%h lo=%h, required hi=%h lo=%h", i, bus.hi, bus.lo, v_hi[i], v_lo[i]);
      end
      idle(1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      idle(1);
    end
  endtask

  // A new start is driven in the very cycle done is high.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_op(2'($urandom), $urandom, pick_operand(), 1'b0);
    end
    idle(1);
  endtask

  // Flush mid-CALC (edge k+10) with a start pulse during busy; afterwards
  // either stay idle or restart immediately.
  task automatic test_flush();
    for (int v = 0; v < 2; v++) begin
      do_op(2'b11, 32'h5678_1234, 32'h0001_0000, 1'b0);
      idle(2);
      bus.start = 1'b1; bus.op = 2'b00; bus.data1 = 32'd5; bus.data2 = 32'd6;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 1; n <= 9; n++) begin
        @(negedge clk);
        bus.start = (n == 3);
        bus.op    = 2'b11;
        bus.data1 = $urandom;
        bus.data2 = $urandom;
      end
      bus.start = 1'b0;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_5678) begin
        n_bad++;
        $display("FAIL flush_calc: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=00001234 lo=00005678",
                 bus.busy, bus.done, bus.hi, bus.lo);
      end
      if (v == 0) begin
        idle(40);
      end else begin
        do_op(2'b00, 32'd5, 32'd6, 1'b0);
        n_cmp++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h0000_001E) begin
          n_bad++;
          $display("FAIL restart_after_flush: hi=%h lo=%h, required hi=00000000 lo=0000001e", bus.hi, bus.lo);
        end
        idle(1);
      end
    end
  endtask

  // Flush sampled on the FIX cycle suppresses the write and done.
  task automatic test_flush_fix();
    bus.start = 1'b1; bus.op = 2'b11; bus.data1 = $urandom; bus.data2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (33) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fix_busy: busy=%b, required 1", bus.busy);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      n_bad++;
      $display("FAIL flush_fix: done=%b busy=%b hi=%h lo=%h, required done=0 busy=0 hi=%h lo=%h",
               bus.done, bus.busy, bus.hi, bus.lo, exp_hi, exp_lo);
    end
    idle(3);
  endtask

  task automatic test_flush_start_idle();
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.data1 = 32'd9; bus.data2 = 32'd9;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_start_idle: busy=%b, required 0", bus.busy);
    end
    idle(40);
  endtask

  // Reset low at cycle 20 of a DIVU clears outputs without a clock edge.
  task automatic test_reset_mid();
    bus.start = 1'b1; bus.op = 2'b11; bus.data1 = 32'hDEAD_BEEF; bus.data2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all zero", bus.busy, bus.done, bus.hi, bus.lo);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    idle(40);
    do_op(2'b10, $urandom, pick_operand(), 1'b0);
    idle(1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_flush();
    test_flush_fix();
    test_flush_start_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameters: none; operand width fixed at 32.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request new operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 data1  input  32  EX-stage forwarded rs operand (multiplicand/dividend).
REQ-007 data2  input  32  EX-stage forwarded rt operand (multiplier/divisor).
REQ-008 flush  input  1  cancel in-flight operation (branch/exception squash).
REQ-009 busy  output  1  high whenever state != IDLE; drives the pipeline stall toward hazard_detection.
REQ-010 done  output  1  single-cycle pulse; hi/lo hold the new result.
REQ-011 hi  output  32  HI result (product[63:32] / remainder), registered.
REQ-012 lo  output  32  LO result (product[31:0] / quotient), registered.

Function
REQ-013 FSM states SHALL be IDLE, PREP, CALC, FIX.
- IDLE->PREP on start & !flush.
- PREP->CALC after 1 cycle.
- CALC->FIX after 32 iterations.
- FIX->IDLE after 1 cycle.
REQ-014 At the IDLE->PREP edge, op, data1 and data2 SHALL be latched; later changes to these inputs are ignored.
REQ-015 PREP SHALL take absolute values for signed ops, record the result signs and clear the 5-bit iteration counter.
REQ-016 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide; the counter wraps 31->0 on exit.
REQ-017 FIX SHALL apply sign correction; on the FIX->IDLE edge hi/lo update and done asserts for exactly one cycle.
REQ-018 Latency: with start sampled at edge k, hi/lo/done are valid after edge k+34; busy is high after edges k..k+33 and low after edge k+34.
REQ-019 Multiply: {hi,lo} SHALL equal the exact 64-bit signed (MULT) or unsigned (MULTU) product.
REQ-020 Divide: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
REQ-021 Divide by zero: hi = data1, lo = 32'hFFFFFFFF, no exception, same latency.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 flush while busy: next edge -> IDLE; hi/lo retain prior values; no done.
REQ-025 flush and start together in IDLE: flush wins, no operation begins.
REQ-026 flush on the FIX cycle SHALL suppress the hi/lo update and done.
REQ-027 A new start SHALL be accepted in the cycle where done is high, because the FSM is already in IDLE.

Reset
REQ-028 rst low SHALL immediately force state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no done pulse.
REQ-030 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-031 Shared package mdu_pkg SHALL hold:
- op encodings MDU_MULT/MULTU/DIV/DIVU;
- state typedef;
- constants DATA_W = 32 and ITER = 32.
REQ-032 Single module, no sub-module.
REQ-033 A 64-bit working register (partial product / remainder:quotient) SHALL be shared by multiply and divide.
REQ-034 All outputs SHALL be registered, except busy, which is decoded from state.

Verification
REQ-035 MULT, data1 = FFFFFFFE, data2 = 3 -> after edge k+34: hi = FFFFFFFF, lo = FFFFFFFA, done = 1 for 1 cycle.
REQ-036 MULTU, FFFFFFFF * FFFFFFFF -> hi = FFFFFFFE, lo = 00000001.
REQ-037 DIV, data1 = FFFFFFF9 (-7), data2 = 2 -> lo = FFFFFFFD, hi = FFFFFFFF; then DIV 80000000 / FFFFFFFF -> lo = 80000000, hi = 0.
REQ-038 DIVU, data1 = 64, data2 = 0 -> hi = 00000064, lo = FFFFFFFF, latency 34.
REQ-039 Flush and start-rejection: preload hi/lo = 1234/5678, start MULT 5*6, pulse flush at cycle 10 -> no done, hi/lo = 1234/5678; start during busy ignored; start the cycle after flush -> hi = 0, lo = 1E at k+34.
REQ-040 Reset mid-operation: rst low at cycle 20 of DIVU -> busy = 0, hi = lo = 0 without a clock edge; no later done.
